hpi_bus_sequencer: RTL and testbench

Hardware sequencer for the CY7C67200 host-port interface (HPI). It replaces bit-banged PIO timing with fixed-timing bus cycles.
Arbitrates round-robin between two requesters:
- A: processor-side bridge.
- B: hardware keycode poller.
Runs one HPI read or write at a time, with programmable setup/strobe/hold widths. Sits between the SoC fabric and the OTG chip pins; drives the data bus tri-state enable.

---
 rtl/hpi_bus_sequencer_if.sv | 39 +++
 rtl/hpi_bus_sequencer.sv | 168 ++++++++++++++++
 tb/tb_hpi_bus_sequencer.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/hpi_bus_sequencer_if.sv
// Bus bundle for hpi_bus_sequencer: two requester ports, read-back/status and the HPI pins.
// The slave modport is the sequencer's view; master is the fabric/pin side.
interface hpi_bus_sequencer_if;
    logic        req_a;
    logic        we_a;
    logic [1:0]  addr_a;
    logic [15:0] wdata_a;
    logic        ack_a;
    logic        req_b;
    logic        we_b;
    logic [1:0]  addr_b;
    logic [15:0] wdata_b;
    logic        ack_b;
    logic [15:0] rdata;
    logic        busy;
    logic [1:0]  hpi_addr;
    logic        hpi_cs_n;
    logic        hpi_r_n;
    logic        hpi_w_n;
    logic [15:0] hpi_dout;
    logic        hpi_dout_en;
    logic [15:0] hpi_din;

    modport slave (
        input  req_a, we_a, addr_a, wdata_a,
        input  req_b, we_b, addr_b, wdata_b,
        input  hpi_din,
        output ack_a, ack_b, rdata, busy,
        output hpi_addr, hpi_cs_n, hpi_r_n, hpi_w_n, hpi_dout, hpi_dout_en
    );

    modport master (
        output req_a, we_a, addr_a, wdata_a,
        output req_b, we_b, addr_b, wdata_b,
        output hpi_din,
        input  ack_a, ack_b, rdata, busy,
        input  hpi_addr, hpi_cs_n, hpi_r_n, hpi_w_n, hpi_dout, hpi_dout_en
    );
endinterface

// File: rtl/hpi_bus_sequencer.sv
// Fixed-timing CY7C67200 HPI bus sequencer with round-robin arbitration between two requesters.
// Optional macro HPI_XFER_CNT_EN adds a 16-bit completed-transfer counter output xfer_cnt.
module hpi_bus_sequencer #(
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 1
) (
    input  logic               clk_clk,
    input  logic               reset_reset,
`ifdef HPI_XFER_CNT_EN
    output logic [15:0]        xfer_cnt,
`endif
    hpi_bus_sequencer_if.slave bus
);

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, DONE} state_t;

    // Counters load width-1 on entry and the state ends when they reach zero.
    localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
    localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);
    localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        gnt_b_q, gnt_b_d;
    logic        last_b_q, last_b_d;
    logic        we_q, we_d;
    logic [1:0]  addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] rdata_q, rdata_d;
    logic        cs_n_q, cs_n_d;
    logic        r_n_q, r_n_d;
    logic        w_n_q, w_n_d;
    logic        dout_en_q, dout_en_d;
    logic        ack_a_q, ack_a_d;
    logic        ack_b_q, ack_b_d;
    logic        busy_q, busy_d;
    logic        pick_b;
    logic        active_d;

    // B wins only when A is idle or A was served last.
    assign pick_b = bus.req_b && (!bus.req_a || !last_b_q);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        gnt_b_d  = gnt_b_q;
        last_b_d = last_b_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (bus.req_a || bus.req_b) begin
                    gnt_b_d  = pick_b;
                    last_b_d = pick_b;
                    we_d     = pick_b ? bus.we_b    : bus.we_a;
                    addr_d   = pick_b ? bus.addr_b  : bus.addr_a;
                    wdata_d  = pick_b ? bus.wdata_b : bus.wdata_a;
                    if (SETUP_CYC == 0) begin
                        state_d = STROBE;
                        cnt_d   = STROBE_LD;
                    end else begin
                        state_d = SETUP;
                        cnt_d   = SETUP_LD;
                    end
                end
            end
            SETUP: begin
                if (cnt_q == 4'd0) begin
                    state_d = STROBE;
                    cnt_d   = STROBE_LD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            STROBE: begin
                if (cnt_q == 4'd0) begin
                    if (!we_q) rdata_d = bus.hpi_din;
                    if (HOLD_CYC == 0) begin
                        state_d = DONE;
                    end else begin
                        state_d = HOLD;
                        cnt_d   = HOLD_LD;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            HOLD: begin
                if (cnt_q == 4'd0) state_d = DONE;
                else               cnt_d   = cnt_q - 4'd1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Pin values are decoded from the next state so every output is a flop.
        active_d  = (state_d == SETUP) || (state_d == STROBE) || (state_d == HOLD);
        cs_n_d    = !active_d;
        r_n_d     = !((state_d == STROBE) && !we_d);
        w_n_d     = !((state_d == STROBE) && we_d);
        dout_en_d = active_d && we_d;
        ack_a_d   = (state_d == DONE) && !gnt_b_d;
        ack_b_d   = (state_d == DONE) && gnt_b_d;
        busy_d    = (state_d != IDLE);
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            gnt_b_q   <= 1'b0;
            last_b_q  <= 1'b1;
            we_q      <= 1'b0;
            addr_q    <= 2'd0;
            wdata_q   <= 16'd0;
            rdata_q   <= 16'd0;
            cs_n_q    <= 1'b1;
            r_n_q     <= 1'b1;
            w_n_q     <= 1'b1;
            dout_en_q <= 1'b0;
            ack_a_q   <= 1'b0;
            ack_b_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            gnt_b_q   <= gnt_b_d;
            last_b_q  <= last_b_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            cs_n_q    <= cs_n_d;
            r_n_q     <= r_n_d;
            w_n_q     <= w_n_d;
            dout_en_q <= dout_en_d;
            ack_a_q   <= ack_a_d;
            ack_b_q   <= ack_b_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.ack_a       = ack_a_q;
    assign bus.ack_b       = ack_b_q;
    assign bus.rdata       = rdata_q;
    assign bus.busy        = busy_q;
    assign bus.hpi_addr    = addr_q;
    assign bus.hpi_cs_n    = cs_n_q;
    assign bus.hpi_r_n     = r_n_q;
    assign bus.hpi_w_n     = w_n_q;
    assign bus.hpi_dout    = wdata_q;
    assign bus.hpi_dout_en = dout_en_q;

`ifdef HPI_XFER_CNT_EN
    logic [15:0] xfer_cnt_q;

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset)            xfer_cnt_q <= 16'd0;
        else if (state_q == DONE)   xfer_cnt_q <= xfer_cnt_q + 16'd1;
    end

    assign xfer_cnt = xfer_cnt_q;
`endif

endmodule

// File: tb/tb_hpi_bus_sequencer.sv
// Scoreboard bench for hpi_bus_sequencer: default-timing instance plus a zero setup/hold instance.
module tb_hpi_bus_sequencer;

    logic clk;
    logic rst;
    int   cyc;
    int   n_chk;
    int   n_fail;
    int   n_xfer;

    typedef struct {
        bit          b;
        logic [15:0] rdata;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] mdl_rdata;

    hpi_bus_sequencer_if bus ();
    hpi_bus_sequencer_if bus0 ();

`ifdef HPI_XFER_CNT_EN
    logic [15:0] xfer_cnt;
    logic [15:0] xfer_cnt0;
`endif

    hpi_bus_sequencer dut (
        .clk_clk     (clk),
        .reset_reset (rst),
`ifdef HPI_XFER_CNT_EN
        .xfer_cnt    (xfer_cnt),
`endif
        .bus         (bus.slave)
    );

    hpi_bus_sequencer #(
        .SETUP_CYC  (0),
        .STROBE_CYC (1),
        .HOLD_CYC   (0)
    ) dut0 (
        .clk_clk     (clk),
        .reset_reset (rst),
`ifdef HPI_XFER_CNT_EN
        .xfer_cnt    (xfer_cnt0),
`endif
        .bus         (bus0.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic sb_push(input bit b, input bit we, input logic [15:0] rd, input int c);
        exp_t e;
        if (!we) mdl_rdata = rd;
        e.b     = b;
        e.rdata = mdl_rdata;
        e.cyc   = c;
        sb.push_back(e);
    endtask

    // Holds a request until its ack is seen, then drops it in the ack cycle.
    task automatic run_req(input bit b, input bit we, input logic [1:0] addr, input logic [15:0] wd);
        int n;
        if (b) begin
            bus.we_b = we; bus.addr_b = addr; bus.wdata_b = wd; bus.req_b = 1'b1;
        end else begin
            bus.we_a = we; bus.addr_a = addr; bus.wdata_a = wd; bus.req_a = 1'b1;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(b ? bus.ack_b : bus.ack_a) && n < 60);
        if (n >= 60) chk(b ? "timeout_b" : "timeout_a", 32'd0, 32'd1);
        if (b) bus.req_b = 1'b0;
        else   bus.req_a = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            n_xfer = 0;
        end else if (bus.ack_a || bus.ack_b) begin
            n_xfer++;
            chk("ack_exclusive", 32'(bus.ack_a & bus.ack_b), 32'd0);
            if (sb.size() == 0) begin
                chk("unexpected_ack", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("ack_who", 32'(bus.ack_b), 32'(e.b));
                chk("ack_rdata", 32'(bus.rdata), 32'(e.rdata));
                if (e.cyc >= 0) chk("ack_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d;
        int n;
        n_chk = 0;
        n_fail = 0;
        mdl_rdata = 16'd0;
        bus.req_a = 1'b0; bus.we_a = 1'b0; bus.addr_a = 2'd0; bus.wdata_a = 16'd0;
        bus.req_b = 1'b0; bus.we_b = 1'b0; bus.addr_b = 2'd0; bus.wdata_b = 16'd0;
        bus.hpi_din = 16'd0;
        bus0.req_a = 1'b0; bus0.we_a = 1'b0; bus0.addr_a = 2'd0; bus0.wdata_a = 16'd0;
        bus0.req_b = 1'b0; bus0.we_b = 1'b0; bus0.addr_b = 2'd0; bus0.wdata_b = 16'd0;
        bus0.hpi_din = 16'd0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Idle after reset
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("idle_cs_n", 32'(bus.hpi_cs_n), 32'd1);
            chk("idle_r_n", 32'(bus.hpi_r_n), 32'd1);
            chk("idle_w_n", 32'(bus.hpi_w_n), 32'd1);
            chk("idle_dout_en", 32'(bus.hpi_dout_en), 32'd0);
            chk("idle_busy", 32'(bus.busy), 32'd0);
        end
        chk("reset_rdata", 32'(bus.rdata), 32'd0);
        chk("reset_dout", 32'(bus.hpi_dout), 32'd0);

        // A write, addr 2, data 0x1234
        d = cyc;
        sb_push(1'b0, 1'b1, 16'd0, d + 5);
        fork
            run_req(1'b0, 1'b1, 2'd2, 16'h1234);
            for (int k = 1; k <= 5; k++) begin
                @(negedge clk);
                chk("wr_cs_n", 32'(bus.hpi_cs_n), (k <= 4) ? 32'd0 : 32'd1);
                chk("wr_w_n", 32'(bus.hpi_w_n), (k == 2 || k == 3) ? 32'd0 : 32'd1);
                chk("wr_r_n", 32'(bus.hpi_r_n), 32'd1);
                chk("wr_dout_en", 32'(bus.hpi_dout_en), (k <= 4) ? 32'd1 : 32'd0);
                chk("wr_busy", 32'(bus.busy), 32'd1);
                if (k <= 4) begin
                    chk("wr_dout", 32'(bus.hpi_dout), 32'h1234);
                    chk("wr_addr", 32'(bus.hpi_addr), 32'd2);
                end
            end
        join
        @(negedge clk);

        // B read, addr 0, pins return 0xBEEF
        bus.hpi_din = 16'hBEEF;
        d = cyc;
        sb_push(1'b1, 1'b0, 16'hBEEF, d + 5);
        fork
            run_req(1'b1, 1'b0, 2'd0, 16'hFFFF);
            for (int k = 1; k <= 5; k++) begin
                @(negedge clk);
                chk("rd_cs_n", 32'(bus.hpi_cs_n), (k <= 4) ? 32'd0 : 32'd1);
                chk("rd_r_n", 32'(bus.hpi_r_n), (k == 2 || k == 3) ? 32'd0 : 32'd1);
                chk("rd_w_n", 32'(bus.hpi_w_n), 32'd1);
                chk("rd_dout_en", 32'(bus.hpi_dout_en), 32'd0);
                if (k <= 4) chk("rd_addr", 32'(bus.hpi_addr), 32'd0);
            end
        join
        @(negedge clk);

        // A read, addr 1, pins return 0x5A5A
        bus.hpi_din = 16'h5A5A;
        d = cyc;
        sb_push(1'b0, 1'b0, 16'h5A5A, d + 5);
        run_req(1'b0, 1'b0, 2'd1, 16'd0);
        bus.hpi_din = 16'h0000;
        @(negedge clk);
        chk("rdata_held", 32'(bus.rdata), 32'h5A5A);
`ifdef HPI_XFER_CNT_EN
        chk("xfer_cnt_3", 32'(xfer_cnt), 32'd3);
`endif

        // Reset during the STROBE phase of a write
        bus.we_a = 1'b1; bus.addr_a = 2'd3; bus.wdata_a = 16'hDEAD; bus.req_a = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_w_n", 32'(bus.hpi_w_n), 32'd0);
        #1 rst = 1'b1;
        #1;
        chk("rst_w_n", 32'(bus.hpi_w_n), 32'd1);
        chk("rst_cs_n", 32'(bus.hpi_cs_n), 32'd1);
        chk("rst_dout_en", 32'(bus.hpi_dout_en), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_rdata", 32'(bus.rdata), 32'd0);
        bus.req_a = 1'b0;
        mdl_rdata = 16'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("post_rst_busy", 32'(bus.busy), 32'd0);
            chk("post_rst_cs_n", 32'(bus.hpi_cs_n), 32'd1);
        end

        // Simultaneous requests after reset, then continuous alternation
        bus.hpi_din = 16'hC0DE;
        d = cyc;
        sb_push(1'b0, 1'b1, 16'd0, d + 5);
        sb_push(1'b1, 1'b0, 16'hC0DE, d + 11);
        fork
            for (int k = 0; k < 3; k++) begin
                if (k > 0) sb_push(1'b0, 1'b1, 16'd0, d + 5 + 12 * k);
                run_req(1'b0, 1'b1, 2'd3, 16'hA000 + 16'(k));
            end
            for (int k = 0; k < 3; k++) begin
                if (k > 0) sb_push(1'b1, 1'b0, 16'hC0DE, d + 11 + 12 * k);
                run_req(1'b1, 1'b0, 2'd1, 16'd0);
            end
        join
        repeat (3) @(negedge clk);
        chk("alt_idle_busy", 32'(bus.busy), 32'd0);
`ifdef HPI_XFER_CNT_EN
        chk("xfer_cnt_total", 32'(xfer_cnt), 32'(n_xfer));
`endif

        // Zero setup/hold, single-cycle strobe: ack at cycle 2
        bus0.hpi_din = 16'h0F0F;
        d = cyc;
        bus0.we_b = 1'b0; bus0.addr_b = 2'd2; bus0.req_b = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                chk("min_r_n", 32'(bus0.hpi_r_n), 32'd0);
                chk("min_cs_n", 32'(bus0.hpi_cs_n), 32'd0);
            end
        end while (!bus0.ack_b && n < 20);
        chk("min_ack_cycle", 32'(cyc), 32'(d + 2));
        chk("min_rdata", 32'(bus0.rdata), 32'h0F0F);
        chk("min_ack_a", 32'(bus0.ack_a), 32'd0);
        bus0.req_b = 1'b0;
        repeat (2) @(negedge clk);
        chk("min_idle_busy", 32'(bus0.busy), 32'd0);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
